// File: rtl/serial_to_parallel_framed.sv
// Serial-to-parallel converter with framing: packs serial bits into WIDTH-bit
// words, closing a word early on serial_last, with a one-deep skid register.
module serial_to_parallel_framed #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    input  logic             serial_last,
    output logic             serial_ready,
    output logic             parallel_valid,
    input  logic             parallel_ready,
    output logic [WIDTH-1:0] parallel_data,
    output logic [CW-1:0]    parallel_count
);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             pending;
    logic [WIDTH-1:0] pend_data;
    logic [CW-1:0]    pend_count;

    logic             s_acc_c;
    logic             o_acc_c;
    logic             slot_free_c;
    logic             done_c;
    logic [CW-1:0]    cnt_inc_c;
    logic [CW-1:0]    pos_c;
    logic [WIDTH-1:0] word_c;

    // Accept qualification, bit placement and word completion
    always_comb begin
        s_acc_c     = serial_valid && !pending;
        o_acc_c     = parallel_valid && parallel_ready;
        slot_free_c = !parallel_valid || parallel_ready;
        cnt_inc_c   = cnt + CW'(1);
        pos_c       = LSB_FIRST ? cnt : (CW'(WIDTH - 1) - cnt);
        word_c      = sh;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CW'(i) == pos_c) begin
                word_c[i] = serial_data;
            end
        end
        done_c      = s_acc_c && (serial_last || (cnt == CW'(WIDTH - 1)));
    end

    // The skid register is the only thing that can stall the serial side
    assign serial_ready = !pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh             <= '0;
            cnt            <= '0;
            pending        <= 1'b0;
            pend_data      <= '0;
            pend_count     <= '0;
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
            parallel_count <= '0;
        end else begin
            if (s_acc_c) begin
                if (done_c) begin
                    sh  <= '0;
                    cnt <= '0;
                end else begin
                    sh  <= word_c;
                    cnt <= cnt_inc_c;
                end
            end

            // No word can complete while pending, since serial_ready is low then
            if (pending) begin
                if (o_acc_c) begin
                    parallel_valid <= 1'b1;
                    parallel_data  <= pend_data;
                    parallel_count <= pend_count;
                    pending        <= 1'b0;
                end
            end else if (done_c) begin
                if (slot_free_c) begin
                    parallel_valid <= 1'b1;
                    parallel_data  <= word_c;
                    parallel_count <= cnt_inc_c;
                end else begin
                    pend_data  <= word_c;
                    pend_count <= cnt_inc_c;
                    pending    <= 1'b1;
                end
            end else if (o_acc_c) begin
                parallel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_framed.sv
// Scoreboard bench: LSB-first and MSB-first instances share one stimulus stream
// and are checked against an occupancy/bit-list reference model.
module tb_serial_to_parallel_framed;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] count;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_valid;
    logic          serial_data;
    logic          serial_last;
    logic          parallel_ready;
    logic          sr0, sr1, pv0, pv1;
    logic [W-1:0]  pd0, pd1;
    logic [CW-1:0] pc0, pc1;

    always #5 clk = ~clk;

    serial_to_parallel_framed #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst),
        .serial_valid(serial_valid), .serial_data(serial_data), .serial_last(serial_last),
        .serial_ready(sr0),
        .parallel_valid(pv0), .parallel_ready(parallel_ready),
        .parallel_data(pd0), .parallel_count(pc0)
    );

    serial_to_parallel_framed #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst),
        .serial_valid(serial_valid), .serial_data(serial_data), .serial_last(serial_last),
        .serial_ready(sr1),
        .parallel_valid(pv1), .parallel_ready(parallel_ready),
        .parallel_data(pd1), .parallel_count(pc1)
    );

    // Model state (written by the monitor only)
    word_t q0[$];
    word_t q1[$];
    logic  bq[$];
    int    occ        = 0;
    bit    seen_rst   = 0;
    bit    after_rst  = 0;
    int    n_vec      = 0;
    int    n_err      = 0;
    int    gold_idx   = 0;
    int    last_epoch = 0;

    // Stimulus-owned state
    word_t g0[$];
    word_t g1[$];
    int    epoch      = 0;
    bit    rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model: evaluated mid-cycle, predicts the next edge
    always @(negedge clk) begin
        bit    o_acc;
        bit    s_acc;
        word_t w0, w1;
        if (rst) begin
            q0.delete(); q1.delete(); bq.delete();
            occ       = 0;
            seen_rst  = 1;
            after_rst = 1;
        end else if (seen_rst) begin
            if (after_rst) begin
                chk("reset_data_lsb", 32'(pd0), 32'h0);
                chk("reset_count_lsb", 32'(pc0), 32'h0);
                chk("reset_data_msb", 32'(pd1), 32'h0);
                chk("reset_count_msb", 32'(pc1), 32'h0);
                after_rst = 0;
            end
            chk("valid_lsb", 32'(pv0), 32'(occ > 0));
            chk("valid_msb", 32'(pv1), 32'(occ > 0));
            chk("ready_lsb", 32'(sr0), 32'(occ < 2));
            chk("ready_msb", 32'(sr1), 32'(occ < 2));
            if (occ > 0) begin
                if (q0.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL word_present: got valid word, expected none queued at %0t", $time);
                end else begin
                    chk("data_lsb", 32'(pd0), 32'(q0[0].data));
                    chk("count_lsb", 32'(pc0), 32'(q0[0].count));
                    chk("data_msb", 32'(pd1), 32'(q1[0].data));
                    chk("count_msb", 32'(pc1), 32'(q1[0].count));
                end
            end
            o_acc = (occ > 0) && (parallel_ready === 1'b1);
            s_acc = (serial_valid === 1'b1) && (occ < 2);
            if (o_acc) begin
                if (gold_idx < g0.size()) begin
                    chk("gold_data_lsb", 32'(pd0), 32'(g0[gold_idx].data));
                    chk("gold_count_lsb", 32'(pc0), 32'(g0[gold_idx].count));
                    chk("gold_data_msb", 32'(pd1), 32'(g1[gold_idx].data));
                    chk("gold_count_msb", 32'(pc1), 32'(g1[gold_idx].count));
                    gold_idx++;
                end
                if (q0.size() > 0) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end
            if (s_acc) begin
                bq.push_back(serial_data);
                if ((serial_last === 1'b1) || (bq.size() == W)) begin
                    w0.data = '0;
                    w1.data = '0;
                    for (int k = 0; k < bq.size(); k++) begin
                        w0.data = w0.data | (W'(bq[k]) << k);
                        w1.data = w1.data | (W'(bq[k]) << (W - 1 - k));
                    end
                    w0.count = CW'(bq.size());
                    w1.count = CW'(bq.size());
                    q0.push_back(w0);
                    q1.push_back(w1);
                    occ++;
                    bq.delete();
                end
            end
            if (o_acc) occ--;
            if (epoch != last_epoch) begin
                chk("gold_all_seen", 32'(gold_idx), 32'(g0.size()));
                last_epoch = epoch;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) parallel_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_bit(input logic b, input logic last);
        bit acc;
        int guard;
        serial_valid = 1'b1;
        serial_data  = b;
        serial_last  = last;
        acc   = 0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = (sr0 === 1'b1);
            tick();
            guard++;
            if (guard > 200) begin
                $display("FAIL send_bit: serial_ready stuck low, expected accept within 200 cycles");
                $fatal(1, "timeout");
            end
        end
        serial_valid = 1'b0;
        serial_last  = 1'b0;
    endtask

    task automatic gap(input int n, input bit last_pulses);
        serial_valid = 1'b0;
        repeat (n) begin
            serial_last = last_pulses ? 1'($urandom_range(0, 1)) : 1'b0;
            serial_data = 1'($urandom_range(0, 1));
            tick();
        end
        serial_last = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n, input bit last_end, input int gap_pct);
        logic [15:0] v;
        v = bits;
        for (int k = 0; k < n; k++) begin
            if (int'($urandom_range(0, 99)) < gap_pct) gap(int'($urandom_range(1, 3)), 1'b1);
            send_bit(v[0], last_end && (k == n - 1));
            v = v >> 1;
        end
    endtask

    task automatic do_reset(input int n);
        rst          = 1'b1;
        serial_valid = 1'b1;
        serial_data  = 1'($urandom_range(0, 1));
        serial_last  = 1'($urandom_range(0, 1));
        repeat (n) tick();
        rst          = 1'b0;
        serial_valid = 1'b0;
        serial_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        serial_valid   = 1'b0;
        rand_ready     = 0;
        parallel_ready = 1'b1;
        guard = 0;
        while (occ != 0) begin
            tick();
            guard++;
            if (guard > 100) begin
                $display("FAIL drain: %0d words still held, expected 0", occ);
                $fatal(1, "timeout");
            end
        end
        tick();
        tick();
        epoch++;
        tick();
        tick();
    endtask

    task automatic push_gold(input logic [W-1:0] d0, input logic [W-1:0] d1, input int c);
        word_t w;
        w.count = CW'(c);
        w.data  = d0;
        g0.push_back(w);
        w.data  = d1;
        g1.push_back(w);
    endtask

    initial begin
        rst            = 1'b1;
        serial_valid   = 1'b0;
        serial_data    = 1'b0;
        serial_last    = 1'b0;
        parallel_ready = 1'b1;
        do_reset(3);

        // 1,0,1,1,0,0,1,0 full word
        push_gold(8'h4D, 8'hB2, 8);
        send_frame(16'h004D, 8, 1'b0, 0);
        drain();

        // short word 1,1,0 then a clean full word
        push_gold(8'h03, 8'hC0, 3);
        push_gold(8'h4D, 8'hB2, 8);
        send_frame(16'h0003, 3, 1'b1, 0);
        send_frame(16'h004D, 8, 1'b0, 0);
        drain();

        // backpressure: A=0xFF shown and held, B=0x0F parked in skid
        parallel_ready = 1'b0;
        push_gold(8'hFF, 8'hFF, 8);
        push_gold(8'h0F, 8'hF0, 8);
        send_frame(16'h0FFF, 16, 1'b0, 0);
        gap(4, 1'b0);
        drain();

        // reset mid-word discards the partial word
        send_frame(16'($urandom), 5, 1'b0, 0);
        do_reset(1);
        push_gold(8'hA5, 8'hA5, 8);
        send_frame(16'h00A5, 8, 1'b0, 0);
        drain();

        // gaps with serial_last pulses while idle
        push_gold(8'hA5, 8'hA5, 8);
        send_frame(16'h00A5, 8, 1'b0, 60);
        drain();

        // random frames, random backpressure, occasional reset
        rand_ready = 1;
        repeat (300) begin
            int n;
            bit le;
            n  = int'($urandom_range(1, W));
            le = (n < int'(W)) || ($urandom_range(0, 1) == 1);
            send_frame(16'($urandom), n, le, 20);
            if ($urandom_range(0, 49) == 0) do_reset(1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_framed.md
SERIAL_TO_PARALLEL_FRAMED -- requirements
Module: serial_to_parallel_framed

Interface
REQ-001 Parameter: WIDTH, default 8, output word width in bits; legal values are WIDTH >= 2.
REQ-002 Parameter: LSB_FIRST, default 1; 1 = first serial bit lands in bit 0, 0 = first serial bit lands in bit WIDTH-1.
REQ-003 Local width CW = $clog2(WIDTH+1).
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 serial_valid  in  1  serial bit present.
REQ-007 serial_data  in  1  serial bit value.
REQ-008 serial_last  in  1  current bit ends the frame; sampled only on a serial accept.
REQ-009 serial_ready  out  1  block can accept a bit this cycle.
REQ-010 parallel_valid  out  1  output word present.
REQ-011 parallel_ready  in  1  downstream accepts the word.
REQ-012 parallel_data  out  WIDTH  assembled word.
REQ-013 parallel_count  out  CW  number of valid bits in parallel_data, 1..WIDTH.

Function
REQ-014 Serial accept occurs when serial_valid && serial_ready; output accept occurs when parallel_valid && parallel_ready.
REQ-015 Assembly state: shift word sh[WIDTH], bit counter cnt[CW] (0..WIDTH-1), pending flag, pending word/count.
REQ-016 The k-th accepted bit of a word (k from 0) is written to position k if LSB_FIRST=1, else to WIDTH-1-k.
REQ-017 A word completes on the accept of the WIDTH-th bit, or on any accept with serial_last=1 (short word).
REQ-018 Positions not written in a short word are 0 in parallel_data.
REQ-019 On completion, cnt and sh are cleared for the next word in the same clock edge.
REQ-020 Output slot free = !parallel_valid || parallel_ready.
REQ-021 On completion with slot free: next cycle parallel_valid=1, parallel_data=word, parallel_count=bits accepted; latency is 1 cycle from the final bit.
REQ-022 On completion with slot not free: word and count go to the pending register and pending=1.
REQ-023 serial_ready = !pending (combinational from state only, independent of serial_valid).
REQ-024 While pending=1, on an output accept the pending word moves to the output next cycle and pending clears; back-to-back words have no bubble.
REQ-025 On an output accept with no new word arriving, parallel_valid drops next cycle.
REQ-026 parallel_data/parallel_count hold stable while parallel_valid && !parallel_ready.
REQ-027 Gaps (serial_valid=0) of any length leave cnt and sh unchanged.
REQ-028 serial_last with serial_valid=0 is ignored; no zero-length words are ever produced.
REQ-029 Throughput: sustains 1 bit/cycle indefinitely when parallel_ready=1.

Reset
REQ-030 rst=1: parallel_valid=0, parallel_data=0, parallel_count=0, cnt=0, sh=0, pending=0; serial_ready=1 from the first cycle after reset.
REQ-031 rst asserted mid-word discards the partial word and any pending or output word; inputs are ignored during rst.

Verification
REQ-032 WIDTH=8, LSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, parallel_ready=1 -> parallel_data=0x4D, count=8, valid for 1 cycle, one cycle after the 8th bit.
REQ-033 Same bits with LSB_FIRST=0 -> parallel_data=0xB2, count=8.
REQ-034 Bits 1,1,0 with serial_last on the 3rd -> LSB_FIRST=1: 0x03, count=3; LSB_FIRST=0: 0xC0, count=3; the next 8 bits form a clean full word.
REQ-035 parallel_ready=0, stream 16 bits (word A=0xFF, then B=0x0F, LSB-first) -> A shown and held stable; serial_ready=0 from the cycle after B completes; raise ready -> A accepted, B appears next cycle, serial_ready=1 in the same cycle B appears.
REQ-036 Send 5 bits, assert rst 1 cycle, then 8 bits of 0xA5 -> output exactly 0xA5, count=8, no stale word.
REQ-037 0xA5 sent with a random serial_valid gap pattern and serial_last pulses while serial_valid=0 -> single word 0xA5, count=8.
